// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: serialises E/M register writes through an in-order FIFO
// and keeps a per-register pending count for decode hazards. Optional: WB_FORWARD_EN.
module regfile_wb_sched #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   e_valid,
  input  logic [AW-1:0]          e_dst,
  input  logic [DW-1:0]          e_data,
  input  logic                   m_valid,
  input  logic [AW-1:0]          m_dst,
  input  logic [DW-1:0]          m_data,
  output logic                   in_ready,
  input  logic [AW-1:0]          src_a,
  input  logic [AW-1:0]          src_b,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_dst,
  output logic [DW-1:0]          wr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   idle,
  output logic                   err_ovf,
  output logic [DW-1:0]          fwd_a_data,
  output logic [DW-1:0]          fwd_b_data
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;
  localparam int PW   = $clog2(DEPTH + 2);
  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] RNONE   = {AW{1'b1}};
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]   fifoDst  [DEPTH];
  logic [DW-1:0]   fifoData [DEPTH];
  logic [PTRW-1:0] rdPtr_q, wrPtr_q, wrPtr_d, mSlot;
  logic [CW-1:0]   count_q, count_d;
  logic            wrEn_q;
  logic [AW-1:0]   wrDst_q;
  logic [DW-1:0]   wrData_q;
  logic            errOvf_q;
  logic [PW-1:0]   pend_q [NREG];
  logic [PW-1:0]   pend_d [NREG];
  logic            reject, pushE, pushM, pop;

  assign in_ready = (DEPTH_C - count_q) >= CW'(2);

  // A rejected cycle drops both requests; RNONE destinations never enter the FIFO.
  always_comb begin
    reject  = (e_valid || m_valid) && !in_ready;
    pushE   = e_valid && (e_dst != RNONE) && !reject;
    pushM   = m_valid && (m_dst != RNONE) && !reject;
    pop     = (count_q != '0);
    count_d = count_q + CW'(pushE) + CW'(pushM) - CW'(pop);
    mSlot   = pushE ? wrPtr_q + PTRW'(1) : wrPtr_q;
    wrPtr_d = wrPtr_q + PTRW'(pushE) + PTRW'(pushM);
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r]
                + PW'(pushE && (e_dst == AW'(r)))
                + PW'(pushM && (m_dst == AW'(r)))
                - PW'(wrEn_q && (wrDst_q == AW'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (pushE) begin
      fifoDst[wrPtr_q]  <= e_dst;
      fifoData[wrPtr_q] <= e_data;
    end
    if (pushM) begin
      fifoDst[mSlot]  <= m_dst;
      fifoData[mSlot] <= m_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      count_q  <= '0;
      wrEn_q   <= 1'b0;
      wrDst_q  <= RNONE;
      wrData_q <= '0;
      errOvf_q <= 1'b0;
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      rdPtr_q  <= rdPtr_q + PTRW'(pop);
      wrPtr_q  <= wrPtr_d;
      count_q  <= count_d;
      wrEn_q   <= pop;
      errOvf_q <= errOvf_q | reject;
      pend_q   <= pend_d;
      if (pop) begin
        wrDst_q  <= fifoDst[rdPtr_q];
        wrData_q <= fifoData[rdPtr_q];
      end else begin
        wrDst_q  <= RNONE;
      end
    end
  end

  assign wr_en   = wrEn_q;
  assign wr_dst  = wrDst_q;
  assign wr_data = wrData_q;
  assign count   = count_q;
  assign idle    = (count_q == '0) && !wrEn_q;
  assign err_ovf = errOvf_q;

`ifdef WB_FORWARD_EN
  logic [PTRW-1:0] idx;

  // Walk oldest to youngest so the last match is the youngest pending value.
  always_comb begin
    fwd_a_data = '0;
    fwd_b_data = '0;
    idx        = '0;
    if (wrEn_q && (wrDst_q == src_a)) fwd_a_data = wrData_q;
    if (wrEn_q && (wrDst_q == src_b)) fwd_b_data = wrData_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PTRW'(i);
      if (CW'(i) < count_q) begin
        if (fifoDst[idx] == src_a) fwd_a_data = fifoData[idx];
        if (fifoDst[idx] == src_b) fwd_b_data = fifoData[idx];
      end
    end
  end

  assign busy_a = 1'b0;
  assign busy_b = 1'b0;
`else
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
  assign busy_a = (src_a != RNONE) && (pend_q[src_a] != '0);
  assign busy_b = (src_b != RNONE) && (pend_q[src_b] != '0);
`endif

endmodule
